data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised byte-addressable data memory for the MIPS datapath, replacing the fixed 100-word, word-indexed RAM. Supports byte, halfword and word loads/stores with sign or zero extension. Uses a req/ready/ack handshake with a configurable number of wait states, so the multicycle and pipelined cores can model slow memory. Detects misaligned and out-of-range accesses and keeps a debug tap of the low half of a chosen word.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
WAIT_STATES, 0, extra cycles between acceptance and ack (0..15)
TEST_WORD, 0, word index exported on test_value

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req  in  1  access request; accepted on a rising edge where req && ready
we  in  1  1 = store, 0 = load; sampled at acceptance
addr  in  32  byte address; sampled at acceptance
wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
ready  out  1  high only in IDLE
ack  out  1  one-cycle completion pulse for every accepted request
rdata  out  32  load result; valid while ack && !err && load
err  out  1  high with ack when the access was rejected
err_misalign  out  1  cause flag, high with err
err_range  out  1  cause flag, high with err
test_value  out  16  combinational mem[TEST_WORD][15:0]

Behaviour:
- Reset (async, rst=0): all memory words = 0. State = IDLE. ready=1 after reset is released. ack, err, err_misalign, err_range = 0. rdata = 0.
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE --accept--> WAIT if WAIT_STATES>0, otherwise straight to RESP.
  - WAIT counts WAIT_STATES cycles, then -> RESP.
  - RESP lasts one cycle, then -> IDLE.
- req is ignored outside IDLE. Throughput is one access per 2+WAIT_STATES cycles.
- Latency: with acceptance at edge E0, ack is high during cycle E0+1+WAIT_STATES.
- Outside RESP, ack=err=0 and the cause flags are 0. rdata holds its last value.
- Address decode: word index = addr[31:2]. Byte lane = addr[1:0], little-endian; lane 0 = bits [7:0].
- Error checks, evaluated at acceptance:
  - err_misalign: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; or size=11.
  - err_range: addr[31:2] >= DEPTH_WORDS.
  - Both flags may be set together.
  - An erroneous request performs no write, still runs the full FSM and wait count, and at ack gives err=1 and rdata=0.
- Store: committed on the acceptance edge.
  - Byte writes only lane addr[1:0] from wdata[7:0].
  - Half writes lanes addr[1]*2 and +1 from wdata[15:0].
  - Word writes all four lanes.
  - Unselected lanes are unchanged. rdata is 0 at ack for a store.
- Load: word read and lane select/extension registered at acceptance; presented on rdata at ack.
  - Byte/half: extended to 32 bits per sign_ext.
  - Word: sign_ext ignored.
- Reset mid-transaction aborts it: no ack, FSM -> IDLE, memory cleared. A store already accepted is lost with the clear.
- test_value follows a store to TEST_WORD in the cycle after the committing edge.

Test Plan:
- Reset then load word at 0x0 -> ready=1 after reset; ack one cycle after acceptance (WAIT_STATES=0); rdata=0x00000000, err=0; test_value=0x0000.
- Store word 0x80FF1234 at 0x10; load byte 0x13 sign_ext=1 -> rdata=0xFFFFFF80; load byte 0x13 sign_ext=0 -> 0x00000080; load half 0x12 sign_ext=1 -> 0xFFFF80FF.
- Store byte 0xAB at 0x11 over 0x80FF1234 -> word load at 0x10 returns 0x80FFAB34; store half 0x5566 at 0x0 -> test_value=0x5566 from the next cycle.
- Load half at 0x3, word at 0x6, size=11 at 0x0 -> each ack with err=1, err_misalign=1, rdata=0. Store word at 4*DEPTH_WORDS -> err_range=1 and memory unchanged.
- WAIT_STATES=3: accept at E0 -> ready low E0+1..E0+4, ack high only in cycle E0+4. req held high meanwhile is not accepted until IDLE.
- Assert rst during WAIT -> no ack, ready=1 after release, previously stored words read back as 0.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the MIPS datapath.
// Byte/half/word loads and stores with sign or zero extension, a req/ready/ack
// handshake with a configurable number of wait states, misalignment and range
// error reporting, and a debug tap on the low half of one chosen word.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0,
    parameter int TEST_WORD   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        err_misalign,
    output logic        err_range,
    output logic [15:0] test_value
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mis_q, rng_q;
    logic [31:0] result_q, result_d;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             acc_misalign;
    logic             acc_range;
    logic             acc_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [31:0]      lane_word;
    logic [31:0]      load_val;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             do_write;

    assign accept    = req && (state_q == S_IDLE);
    assign acc_range = (addr[31:2] >= DEPTH_W);
    assign acc_err   = acc_misalign || acc_range;
    assign word_idx  = addr[IDX_W+1:2];
    assign do_write  = accept && we && !acc_err;

    // Alignment rule per access size; the reserved size is always rejected.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        acc_misalign = 1'b0;
        unique case (size)
            SZ_BYTE: acc_misalign = 1'b0;
            SZ_HALF: acc_misalign = addr[0];
            SZ_WORD: acc_misalign = |addr[1:0];
            default: acc_misalign = 1'b1;
        endcase
    end

    // Read the addressed word, pick the lane and extend it for a load.
    always_comb begin
        rd_word   = acc_range ? 32'd0 : mem_q[word_idx];
        lane_word = rd_word >> {addr[1:0], 3'b000};
        load_val  = rd_word;
        unique case (size)
            SZ_BYTE: load_val = sign_ext ? {{24{lane_word[7]}}, lane_word[7:0]}
                                         : {24'd0, lane_word[7:0]};
            SZ_HALF: load_val = sign_ext ? {{16{lane_word[15]}}, lane_word[15:0]}
                                         : {16'd0, lane_word[15:0]};
            default: load_val = rd_word;
        endcase
        result_d = (acc_err || we) ? 32'd0 : load_val;
    end

    // Byte enables and lane-replicated write data for a store.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = wdata;
        unique case (size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << addr[1:0];
                wr_data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata;
            end
        endcase
    end

    // Storage array: cleared by reset, byte-masked writes on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the array is reset because a cleared memory after reset is part of this block's behaviour; that forces flops rather than a RAM macro.
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Handshake FSM: IDLE -> (WAIT for WAIT_STATES cycles) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, wait counter and per-request status captured at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            mis_q    <= 1'b0;
            rng_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                mis_q    <= acc_misalign;
                rng_q    <= acc_range;
                result_q <= result_d;
            end
        end
    end

    // rdata changes only on the edge that enters RESP and holds afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
        end else if (state_d == S_RESP && state_q != S_RESP) begin
            rdata_q <= (state_q == S_IDLE) ? result_d : result_q;
        end
    end

    assign ready        = (state_q == S_IDLE);
    assign ack          = (state_q == S_RESP);
    assign err          = ack && (mis_q || rng_q);
    assign err_misalign = ack && mis_q;
    assign err_range    = ack && rng_q;
    assign rdata        = rdata_q;
    assign test_value   = mem_q[TEST_WORD][15:0];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Testbench for data_memory_ctrl: one zero-wait instance checked against a
// byte-array reference model, one three-wait-state instance for handshake timing
// and mid-transaction reset.
module tb_data_memory_ctrl;

    localparam int A_DEPTH = 64;
    localparam int B_DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WAIT_STATES=0, TEST_WORD=0
    logic        a_rst, a_req, a_we, a_sext;
    logic [31:0] a_addr, a_wdata;
    logic [1:0]  a_size;
    logic        a_ready, a_ack, a_err, a_mis, a_rng;
    logic [31:0] a_rdata;
    logic [15:0] a_tv;

    // Instance B: WAIT_STATES=3, TEST_WORD=5
    logic        b_rst, b_req, b_we, b_sext;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_size;
    logic        b_ready, b_ack, b_err, b_mis, b_rng;
    logic [31:0] b_rdata;
    logic [15:0] b_tv;

    data_memory_ctrl #(.DEPTH_WORDS(A_DEPTH), .WAIT_STATES(0), .TEST_WORD(0)) dut_a (
        .clk(clk), .rst(a_rst), .req(a_req), .we(a_we), .addr(a_addr),
        .wdata(a_wdata), .size(a_size), .sign_ext(a_sext), .ready(a_ready),
        .ack(a_ack), .rdata(a_rdata), .err(a_err), .err_misalign(a_mis),
        .err_range(a_rng), .test_value(a_tv)
    );

    data_memory_ctrl #(.DEPTH_WORDS(B_DEPTH), .WAIT_STATES(3), .TEST_WORD(5)) dut_b (
        .clk(clk), .rst(b_rst), .req(b_req), .we(b_we), .addr(b_addr),
        .wdata(b_wdata), .size(b_size), .sign_ext(b_sext), .ready(b_ready),
        .ack(b_ack), .rdata(b_rdata), .err(b_err), .err_misalign(b_mis),
        .err_range(b_rng), .test_value(b_tv)
    );

    // Reference memory for instance A as a flat little-endian byte array.
    logic [7:0] model_a [4*A_DEPTH];

    // One access on A: model predicts flags/data, then handshake and results are compared.
    task automatic access_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic sext,
                            output logic [31:0] got_rd, output logic [2:0] got_flags);
        logic        exp_mis, exp_rng;
        logic [31:0] exp_rd;
        int          n, lat, w;
        exp_mis = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
                  (size == 2'd2 && (addr % 4) != 0);
        exp_rng = (addr / 4) >= A_DEPTH;
        exp_rd  = 32'd0;
        n       = 1 << size;
        @(negedge clk);
        w = 0;
        while (a_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_ready_wait: ready=%b required 1", a_ready);
        end
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_size = size; a_sext = sext;
        @(negedge clk);
        a_req = 1'b0;
        if (!exp_mis && !exp_rng) begin
            if (we) begin
                for (int i = 0; i < n; i++) model_a[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(model_a[int'(addr) + i]) << (8*i));
                if (sext && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*n));
            end
        end
        lat = 1;
        while (a_ack !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got_rd    = a_rdata;
        got_flags = {a_err, a_mis, a_rng};
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL a_latency addr=%h: cycles=%0d required 1", addr, lat);
        end
        checks++;
        if (a_rdata !== exp_rd) begin
            errors++;
            $display("FAIL a_rdata we=%b addr=%h size=%0d sext=%b: got %h required %h",
                     we, addr, size, sext, a_rdata, exp_rd);
        end
        checks++;
        if ({a_err, a_mis, a_rng} !== {exp_mis || exp_rng, exp_mis, exp_rng}) begin
            errors++;
            $display("FAIL a_flags addr=%h size=%0d: err/mis/rng=%b required %b",
                     addr, size, {a_err, a_mis, a_rng}, {exp_mis || exp_rng, exp_mis, exp_rng});
        end
        checks++;
        if (a_tv !== {model_a[1], model_a[0]}) begin
            errors++;
            $display("FAIL a_test_value: got %h required %h", a_tv, {model_a[1], model_a[0]});
        end
        @(negedge clk);
        checks++;
        if ({a_ack, a_err, a_rdata} !== {1'b0, 1'b0, exp_rd}) begin
            errors++;
            $display("FAIL a_after_ack: ack=%b err=%b rdata=%h required 0 0 %h",
                     a_ack, a_err, a_rdata, exp_rd);
        end
    endtask

    // One access on B with a caller-supplied expected rdata; latency must be 1+3.
    task automatic access_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic [31:0] exp_rd);
        int lat, w;
        @(negedge clk);
        w = 0;
        while (b_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_size = size; b_sext = 1'b0;
        @(negedge clk);
        b_req = 1'b0;
        lat = 1;
        while (b_ack !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL b_latency addr=%h: cycles=%0d required 4", addr, lat);
        end
        checks++;
        if ({b_err, b_rdata} !== {1'b0, exp_rd}) begin
            errors++;
            $display("FAIL b_result addr=%h: err=%b rdata=%h required 0 %h", addr, b_err, b_rdata, exp_rd);
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_size = '0; a_sext = 1'b0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_size = '0; b_sext = 1'b0;
        for (int i = 0; i < 4*A_DEPTH; i++) model_a[i] = 8'h00;
        #22;
        a_rst = 1'b1; b_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ready, a_ack, a_err, a_mis, a_rng, a_rdata, a_tv} !== {5'b10000, 32'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_a: rdy/ack/err/mis/rng=%b rdata=%h tv=%h required 10000 0 0",
                     {a_ready, a_ack, a_err, a_mis, a_rng}, a_rdata, a_tv);
        end
        checks++;
        if ({b_ready, b_ack, b_err, b_rdata, b_tv} !== {3'b100, 32'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_b: rdy/ack/err=%b rdata=%h tv=%h required 100 0 0",
                     {b_ready, b_ack, b_err}, b_rdata, b_tv);
        end
    endtask

    task automatic test_extension();
        logic [31:0] rd;
        logic [2:0]  fl;
        access_a(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, fl);
        access_a(1'b1, 32'h10, 32'h80FF_1234, 2'd2, 1'b0, rd, fl);
        access_a(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, rd, fl);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_sext: got %h required ffffff80", rd);
        end
        access_a(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, rd, fl);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu: got %h required 00000080", rd);
        end
        access_a(1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd, fl);
        checks++;
        if (rd !== 32'hFFFF_80FF) begin
            errors++;
            $display("FAIL lh_sext: got %h required ffff80ff", rd);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        logic [2:0]  fl;
        access_a(1'b1, 32'h11, 32'h0000_00AB, 2'd0, 1'b0, rd, fl);
        access_a(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, fl);
        checks++;
        if (rd !== 32'h80FF_AB34) begin
            errors++;
            $display("FAIL sb_merge: got %h required 80ffab34", rd);
        end
        access_a(1'b1, 32'h0, 32'h1234_5566, 2'd1, 1'b0, rd, fl);
        checks++;
        if (a_tv !== 16'h5566) begin
            errors++;
            $display("FAIL sh_test_value: got %h required 5566", a_tv);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic [2:0]  fl;
        access_a(1'b0, 32'h3, 32'h0, 2'd1, 1'b1, rd, fl);
        checks++;
        if ({fl, rd} !== {3'b110, 32'd0}) begin
            errors++;
            $display("FAIL mis_half: flags=%b rdata=%h required 110 0", fl, rd);
        end
        access_a(1'b0, 32'h6, 32'h0, 2'd2, 1'b0, rd, fl);
        access_a(1'b0, 32'h0, 32'h0, 2'd3, 1'b0, rd, fl);
        checks++;
        if ({fl, rd} !== {3'b110, 32'd0}) begin
            errors++;
            $display("FAIL mis_reserved: flags=%b rdata=%h required 110 0", fl, rd);
        end
        access_a(1'b1, 32'(4*A_DEPTH), 32'hDEAD_BEEF, 2'd2, 1'b0, rd, fl);
        checks++;
        if (fl !== 3'b101) begin
            errors++;
            $display("FAIL range_store: flags=%b required 101", fl);
        end
        access_a(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, fl);
        access_a(1'b1, 32'(4*A_DEPTH + 2), 32'h0, 2'd2, 1'b0, rd, fl);
        checks++;
        if (fl !== 3'b111) begin
            errors++;
            $display("FAIL both_flags: flags=%b required 111", fl);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        logic [2:0]  fl;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) < 8) addr = 32'($urandom_range(0, 4*A_DEPTH + 3));
            else addr = $urandom;
            access_a(1'($urandom_range(0, 1)), addr, $urandom, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), rd, fl);
        end
    endtask

    task automatic test_wait_states();
        int lat;
        access_b(1'b1, 32'h14, 32'hCAFE_F00D, 2'd2, 32'd0);
        checks++;
        if (b_tv !== 16'hF00D) begin
            errors++;
            $display("FAIL b_test_value: got %h required f00d", b_tv);
        end
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h14; b_size = 2'd2;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({b_ready, b_ack} !== {1'b0, k == 4}) begin
                errors++;
                $display("FAIL b_timing k=%0d: ready/ack=%b required %b", k, {b_ready, b_ack}, {1'b0, k == 4});
            end
        end
        checks++;
        if (b_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b_load: got %h required cafef00d", b_rdata);
        end
        @(negedge clk);
        checks++;
        if ({b_ready, b_ack} !== 2'b10) begin
            errors++;
            $display("FAIL b_idle_gap: ready/ack=%b required 10", {b_ready, b_ack});
        end
        @(negedge clk);
        b_req = 1'b0;
        checks++;
        if (b_ready !== 1'b0) begin
            errors++;
            $display("FAIL b_second_accept: ready=%b required 0", b_ready);
        end
        lat = 1;
        while (b_ack !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL b_second_latency: cycles=%0d required 4", lat);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h14; b_size = 2'd2;
        @(negedge clk);
        b_req = 1'b0;
        @(negedge clk);
        #2 b_rst = 1'b0;
        acks = 0;
        @(negedge clk);
        if (b_ack === 1'b1) acks++;
        #2 b_rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b_ack === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL reset_mid_ack: acks=%0d required 0", acks);
        end
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: ready=%b required 1", b_ready);
        end
        access_b(1'b0, 32'h14, 32'h0, 2'd2, 32'd0);
        checks++;
        if (b_tv !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_tv: got %h required 0000", b_tv);
        end
    endtask

    initial begin
        test_reset();
        test_extension();
        test_partial_store();
        test_errors();
        test_random();
        test_wait_states();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
